// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and bubble clearing.
// Optional two-entry skid buffer when PIPE_SKID_EN is defined; in_ready is then registered.
//
// Parameters:
//   WIDTH      payload width in bits
//   RESET_VAL  payload value after reset, and after flush/bubble when CLEAR_DATA=1
//   CLEAR_DATA 1 = payload forced to RESET_VAL when its entry goes invalid, 0 = hold
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   FLUSH               drop all held entries and the beat presented this cycle
//   in_valid/in_data    upstream beat, in_ready back to upstream
//   out_valid/out_data  downstream beat (registered), out_ready from downstream
//   occupancy           number of valid entries held
// Configuration macro: PIPE_SKID_EN (adds the skid entry behind the main entry).

module pipe_stage_reg #(
  parameter int unsigned      WIDTH      = 64,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               CLEAR_DATA = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic             main_v;
  logic             main_v_n;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_d_n;
  logic             take_in;

  // Payload an entry takes on when it goes empty.
  function automatic logic [WIDTH-1:0] empty_val(
    input logic [WIDTH-1:0] held
  );
    return CLEAR_DATA ? RESET_VAL : held;
  endfunction

  assign out_valid = main_v;
  assign out_data  = main_d;
  assign take_in   = in_valid && in_ready;

`ifdef PIPE_SKID_EN

  logic             skid_v;
  logic             skid_v_n;
  logic [WIDTH-1:0] skid_d;
  logic [WIDTH-1:0] skid_d_n;
  logic             main_free;

  // Registered: depends only on skid state, never on out_ready.
  assign in_ready  = !skid_v;
  // Main can be refilled when empty or draining this edge.
  assign main_free = !main_v || out_ready;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  always_comb begin
    main_v_n = main_v;
    main_d_n = main_d;
    skid_v_n = skid_v;
    skid_d_n = skid_d;
    if (main_free) begin
      if (skid_v) begin
        // Oldest beat moves up; keeps FIFO order.
        main_v_n = 1'b1;
        main_d_n = skid_d;
        if (take_in) begin
          skid_v_n = 1'b1;
          skid_d_n = in_data;
        end else begin
          skid_v_n = 1'b0;
          skid_d_n = empty_val(skid_d);
        end
      end else if (take_in) begin
        main_v_n = 1'b1;
        main_d_n = in_data;
      end else begin
        main_v_n = 1'b0;
        main_d_n = empty_val(main_d);
      end
    end else if (take_in) begin
      // Main stalled: park the beat behind it.
      skid_v_n = 1'b1;
      skid_d_n = in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      main_v <= 1'b0;
      main_d <= RESET_VAL;
      skid_v <= 1'b0;
      skid_d <= RESET_VAL;
    end else if (FLUSH) begin
      main_v <= 1'b0;
      main_d <= empty_val(main_d);
      skid_v <= 1'b0;
      skid_d <= empty_val(skid_d);
    end else begin
      main_v <= main_v_n;
      main_d <= main_d_n;
      skid_v <= skid_v_n;
      skid_d <= skid_d_n;
    end
  end

`else

  // Combinational path from out_ready: a full stage refills as it drains.
  assign in_ready  = out_ready || !main_v;
  assign occupancy = {1'b0, main_v};

  always_comb begin
    main_v_n = main_v;
    main_d_n = main_d;
    if (in_ready) begin
      main_v_n = in_valid;
      if (in_valid) begin
        main_d_n = in_data;
      end else begin
        main_d_n = empty_val(main_d);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      main_v <= 1'b0;
      main_d <= RESET_VAL;
    end else if (FLUSH) begin
      main_v <= 1'b0;
      main_d <= empty_val(main_d);
    end else begin
      main_v <= main_v_n;
      main_d <= main_d_n;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table plus stall/flush/reset sequences.
// Expectations follow PIPE_SKID_EN when it is defined.

module tb_pipe_stage_reg;

  localparam logic [63:0] RV2 = 64'h0000_0000_0000_DEAD;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        iv;
  logic [63:0] idata;
  logic        ordy;

  logic        ir1, ov1, ir2, ov2;
  logic [63:0] od1, od2;
  logic [1:0]  occ1, occ2;

  int n_vec;
  int n_bad;

  pipe_stage_reg #(
    .WIDTH(64), .RESET_VAL(64'h0), .CLEAR_DATA(1'b1)
  ) dut (
    .CLK(clk), .RST(rst), .FLUSH(flush),
    .in_valid(iv), .in_data(idata), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(ordy),
    .occupancy(occ1)
  );

  pipe_stage_reg #(
    .WIDTH(64), .RESET_VAL(RV2), .CLEAR_DATA(1'b0)
  ) dut_hold (
    .CLK(clk), .RST(rst), .FLUSH(flush),
    .in_valid(iv), .in_data(idata), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_ready(ordy),
    .occupancy(occ2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] d;
    logic        ordy;
    logic        chk_ir;
    logic        e_ir;
    logic        e_v;
    logic [63:0] e_d;
    logic [1:0]  e_occ;
    logic [63:0] e_d2;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [63:0] d, input logic o);
    rst = r; flush = f; iv = v; idata = d; ordy = o;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int i, input logic r, input logic v,
                         input logic [63:0] d, input logic o,
                         input logic ci, input logic eir,
                         input logic ev, input logic [63:0] ed,
                         input logic [1:0] eo, input logic [63:0] ed2);
    tbl[i] = '{r, v, d, o, ci, eir, ev, ed, eo, ed2};
  endtask

  task automatic post(input string nm, input logic ev,
                      input logic [63:0] ed, input logic [1:0] eo);
    chk({nm, ".valid"}, {63'd0, ov1}, {63'd0, ev});
    chk({nm, ".data"}, od1, ed);
    chk({nm, ".occ"}, {62'd0, occ1}, {62'd0, eo});
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1; flush = 1'b0; iv = 1'b0; idata = '0; ordy = 1'b1;

    set_row(0, 1, 0, 0, 1, 0, 1, 0, 0, 0, RV2);
    set_row(1, 1, 0, 0, 1, 1, 1, 0, 0, 0, RV2);
    set_row(2, 0, 0, 0, 1, 1, 1, 0, 0, 0, RV2);
    for (int k = 1; k <= 8; k++)
      set_row(2 + k, 0, 1, 64'(k), 1, 1, 1, 1, 64'(k), 1, 64'(k));
    set_row(11, 0, 0, 0, 1, 1, 1, 0, 0, 0, 64'h8);
    set_row(12, 0, 1, 64'h5, 1, 1, 1, 1, 64'h5, 1, 64'h5);
    set_row(13, 0, 0, 0, 1, 1, 1, 0, 0, 0, 64'h5);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, 1'b0, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      if (tbl[i].chk_ir)
        chk($sformatf("v%0d.in_ready", i), {63'd0, ir1},
            {63'd0, tbl[i].e_ir});
      step();
      post($sformatf("v%0d", i), tbl[i].e_v, tbl[i].e_d, tbl[i].e_occ);
      chk($sformatf("v%0d.hold_data", i), od2, tbl[i].e_d2);
    end

    // Stall with 0xA held, 0xB offered.
    drive(0, 0, 1, 64'hA, 0);
    chk("stall.ir_empty", {63'd0, ir1}, 64'd1);
    step();
    post("stall.loadA", 1, 64'hA, 1);
    drive(0, 0, 1, 64'hB, 0);
`ifdef PIPE_SKID_EN
    chk("stall.ir_B", {63'd0, ir1}, 64'd1);
    step();
    post("stall.skidB", 1, 64'hA, 2);
`else
    chk("stall.ir_B", {63'd0, ir1}, 64'd0);
    step();
    post("stall.rejB", 1, 64'hA, 1);
`endif
    drive(0, 0, 0, 64'h0, 0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall.ir%0d", c), {63'd0, ir1}, 64'd0);
      step();
      chk($sformatf("stall.data%0d", c), od1, 64'hA);
      chk($sformatf("stall.valid%0d", c), {63'd0, ov1}, 64'd1);
    end
    drive(0, 0, 0, 64'h0, 1);
    step();
`ifdef PIPE_SKID_EN
    post("release.B", 1, 64'hB, 1);
    chk("release.ir", {63'd0, ir1}, 64'd1);
    step();
`endif
    post("release.empty", 0, 64'h0, 0);

    // Flush during stall drops held 0xA and incoming 0xC.
    drive(0, 0, 1, 64'hA, 0);
    step();
    post("flush.loadA", 1, 64'hA, 1);
    drive(0, 1, 1, 64'hC, 0);
    step();
    post("flush.edge", 0, 64'h0, 0);
    chk("flush.hold_data", od2, 64'hA);
    chk("flush.hold_valid", {63'd0, ov2}, 64'd0);
    drive(0, 0, 0, 64'h0, 1);
    step();
    post("flush.noC", 0, 64'h0, 0);
    chk("flush.noC_hold", od2, 64'hA);

    // Reset in the middle of a stall.
    drive(0, 0, 1, 64'h11, 0);
    step();
    drive(0, 0, 1, 64'h22, 0);
    step();
`ifdef PIPE_SKID_EN
    post("rststall.full", 1, 64'h11, 2);
`else
    post("rststall.full", 1, 64'h11, 1);
`endif
    drive(1, 0, 0, 64'h0, 0);
    step();
    post("rststall.rst", 0, 64'h0, 0);
    chk("rststall.ir", {63'd0, ir1}, 64'd1);
    chk("rststall.hold_data", od2, RV2);
    drive(0, 0, 0, 64'h0, 1);
    step();
    post("rststall.after", 0, 64'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
